// File: rtl/conv_pkg.sv
// Shared types and default sizing for the 1-D convolution controller.
package conv_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MAC   = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } conv_state_t;

    localparam int N_DEF = 32;
    localparam int M_DEF = 4;

endpackage

// File: rtl/conv_ctrl_cnt.sv
// Wrapping up-counter: counts 0..MAX on en, wraps to 0 after MAX, clr has priority.
module conv_ctrl_cnt #(
    parameter int W   = 5,
    parameter int MAX = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign tc = (cnt == MAX_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/conv_ctrl.sv
// Sequencing FSM for the 1-D convolution datapath: loads N samples, then runs
// N-M+1 dot products of M taps each, presenting every result on a valid/ready port.
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int M   = M_DEF,
    parameter int AXW = $clog2(N),
    parameter int AFW = $clog2(M)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           x_valid,
    output logic           x_ready,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           wr_en_x,
    output logic [AXW-1:0] addr_x,
    output logic [AFW-1:0] addr_f,
    output logic           clear_acc,
    output logic           en_acc
);

    conv_state_t    state;
    conv_state_t    state_nxt;

    logic [AXW-1:0] ld;
    logic [AXW-1:0] i;
    logic [AFW-1:0] k;
    logic           ld_tc;
    logic           i_tc;
    logic           k_tc;

    logic           x_hs;
    logic           y_hs;
    logic           load_done;
    logic           ld_clr;
    logic           i_clr;
    logic           i_en;
    logic           k_clr;
    logic           k_en;
    logic [AXW:0]   tap_addr;

    // Handshakes are masked by reset so nothing completes while it is held.
    assign x_hs      = !reset && (state == S_LOAD) && x_valid;
    assign y_hs      = !reset && (state == S_OUT) && y_ready;
    assign load_done = x_hs && ld_tc;

    // i+k is formed one bit wider; with i<=N-M and k<=M-1 it never exceeds N-1.
    assign tap_addr  = (AXW+1)'(i) + (AXW+1)'(k);

    assign ld_clr = (state != S_LOAD);
    assign i_clr  = load_done || (y_hs && i_tc);
    assign i_en   = y_hs && !i_tc;
    assign k_clr  = load_done || (state == S_FLUSH);
    assign k_en   = (state == S_MAC);

    conv_ctrl_cnt #(
        .W   (AXW),
        .MAX (N - 1)
    ) u_cnt_ld (
        .clk   (clk),
        .reset (reset),
        .clr   (ld_clr),
        .en    (x_hs),
        .cnt   (ld),
        .tc    (ld_tc)
    );

    conv_ctrl_cnt #(
        .W   (AXW),
        .MAX (N - M)
    ) u_cnt_i (
        .clk   (clk),
        .reset (reset),
        .clr   (i_clr),
        .en    (i_en),
        .cnt   (i),
        .tc    (i_tc)
    );

    conv_ctrl_cnt #(
        .W   (AFW),
        .MAX (M - 1)
    ) u_cnt_k (
        .clk   (clk),
        .reset (reset),
        .clr   (k_clr),
        .en    (k_en),
        .cnt   (k),
        .tc    (k_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (load_done) state_nxt = S_MAC;
            S_MAC:   if (k_tc) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_OUT;
            S_OUT:   if (y_hs) state_nxt = i_tc ? S_LOAD : S_MAC;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Read data arrives one cycle after the address, so accumulate lags the tap by one.
    always_comb begin
        x_ready   = 1'b0;
        y_valid   = 1'b0;
        wr_en_x   = 1'b0;
        addr_x    = '0;
        addr_f    = '0;
        clear_acc = 1'b0;
        en_acc    = 1'b0;
        if (!reset) begin
            case (state)
                S_LOAD: begin
                    x_ready   = 1'b1;
                    wr_en_x   = x_valid;
                    addr_x    = ld;
                    clear_acc = load_done;
                end
                S_MAC: begin
                    addr_x = AXW'(tap_addr);
                    addr_f = k;
                    en_acc = (k != '0);
                end
                S_FLUSH: begin
                    en_acc = 1'b1;
                end
                S_OUT: begin
                    y_valid   = 1'b1;
                    clear_acc = y_hs && !i_tc;
                end
                default: begin
                    x_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: datapath model (1-cycle read memories + MAC) plus a
// vector-level scoreboard of expected dot products and handshake rules.
module tb_conv_ctrl;

    localparam int N    = 32;
    localparam int M    = 4;
    localparam int AXW  = 5;
    localparam int AFW  = 2;
    localparam int NOUT = N - M + 1;
    localparam int NVEC = 100;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           x_valid = 1'b0;
    logic           y_ready = 1'b0;
    logic [7:0]     x_data = 8'd1;
    logic           x_ready;
    logic           y_valid;
    logic           wr_en_x;
    logic [AXW-1:0] addr_x;
    logic [AFW-1:0] addr_f;
    logic           clear_acc;
    logic           en_acc;

    conv_ctrl #(.N(N), .M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .wr_en_x   (wr_en_x),
        .addr_x    (addr_x),
        .addr_f    (addr_f),
        .clear_acc (clear_acc),
        .en_acc    (en_acc)
    );

    always #5 clk = ~clk;

    // Datapath: x memory, filter ROM, MAC accumulator.
    int xmem [N];
    int from [M] = '{1, 2, 3, 4};
    int xr = 0;
    int fr = 0;
    int acc = 0;

    always @(posedge clk) begin
        if (wr_en_x) xmem[addr_x] <= int'(x_data);
        xr <= xmem[addr_x];
        fr <= from[addr_f];
        if (clear_acc) acc <= 0;
        else if (en_acc) acc <= acc + xr * fr;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state
    int   cyc = 0;
    int   vec[$];
    int   yq[$];
    int   vec_y = 0;
    int   n_xhs = 0;
    int   n_yhs = 0;
    int   last_x_cyc = 0;
    int   last_y_cyc = 0;
    logic prev_yv = 1'b0;
    logic prev_hs = 1'b0;
    int   prev_acc = 0;
    logic exp_xr = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_outputs", longint'({x_ready, y_valid, wr_en_x, clear_acc, en_acc, addr_x, addr_f}), 0);
            vec.delete();
            yq.delete();
            vec_y = 0;
            prev_yv = 1'b0;
            prev_hs = 1'b0;
            exp_xr = 1'b0;
        end else begin
            chk("acc_ctrl_excl", longint'(en_acc && clear_acc), 0);
            chk("xr_yv_excl", longint'(x_ready && y_valid), 0);
            if (exp_xr) chk("x_ready_return", longint'(x_ready), 1);
            exp_xr = 1'b0;
            if (prev_yv && !prev_hs) begin
                chk("y_hold", longint'(y_valid), 1);
                chk("y_stable", acc, prev_acc);
            end
            if (x_valid && x_ready) begin
                chk("wr_en_x", longint'(wr_en_x), 1);
                chk("addr_x_load", longint'(addr_x), vec.size());
                vec.push_back(int'(x_data));
                n_xhs++;
                if (vec.size() == N) begin
                    chk("clear_on_last_x", longint'(clear_acc), 1);
                    for (int o = 0; o < NOUT; o++) begin
                        int s;
                        s = 0;
                        for (int t = 0; t < M; t++) s += vec[o + t] * from[t];
                        yq.push_back(s);
                    end
                    vec.delete();
                    vec_y = 0;
                    last_x_cyc = cyc;
                end else begin
                    chk("no_clear_mid_load", longint'(clear_acc), 0);
                end
            end else begin
                chk("wr_en_idle", longint'(wr_en_x), 0);
            end
            if (y_valid) begin
                chk("out_quiet", longint'({en_acc, addr_x, addr_f, wr_en_x}), 0);
                chk("out_clear", longint'(clear_acc), longint'(y_ready && (vec_y != NOUT - 1)));
                if (!prev_yv)
                    chk("y_spacing", cyc - ((vec_y == 0) ? last_x_cyc : last_y_cyc), M + 2);
                if (y_ready) begin
                    if (yq.size() == 0) chk("y_unexpected", 1, 0);
                    else chk("y_data", acc, yq.pop_front());
                    n_yhs++;
                    last_y_cyc = cyc;
                    vec_y++;
                    if (vec_y == NOUT) begin
                        vec_y = 0;
                        exp_xr = 1'b1;
                    end
                end
            end
            prev_yv = y_valid;
            prev_hs = y_valid && y_ready;
            prev_acc = acc;
        end
    end

    initial begin
        int n;
        int s_x;
        int s_y;
        int hold;

        // Reset, then ramp vector x[n]=n+1 with y_ready high throughout.
        reset = 1'b1;
        x_valid = 1'b1;
        y_ready = 1'b1;
        x_data = 8'd1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int j = 0; j <= 206; j++) begin
            @(negedge clk);
            if (j < 32) begin
                chk("t1_addr", longint'(addr_x), j);
                chk("t1_xready", longint'(x_ready), 1);
            end
            if (j == 31) chk("t1_clear_last", longint'(clear_acc), 1);
            if (j == 32) chk("t1_xready_drop", longint'(x_ready), 0);
            if (j == 36) chk("t2_no_y_yet", longint'(y_valid), 0);
            if (j == 37) begin
                chk("t2_first_y", longint'(y_valid), 1);
                chk("t2_y0", acc, 30);
            end
            if (j == 43) begin
                chk("t2_second_y", longint'(y_valid), 1);
                chk("t2_y1", acc, 40);
            end
            if (j >= 200 && j <= 203) begin
                chk("t3_addr_x", longint'(addr_x), j - 172);
                chk("t3_addr_f", longint'(addr_f), j - 200);
            end
            if (j == 200) chk("t3_en_first", longint'(en_acc), 0);
            if (j >= 201 && j <= 204) chk("t3_en_acc", longint'(en_acc), 1);
            if (j == 205) begin
                chk("t3_y28_valid", longint'(y_valid), 1);
                chk("t3_y28", acc, 310);
            end
            if (j == 206) chk("t2_xready_back", longint'(x_ready), 1);
            @(posedge clk);
            #1;
            x_data = 8'(j + 2);
            if (j == 31) x_valid = 1'b0;
        end

        // Stall the output for 20 cycles.
        x_valid = 1'b1;
        y_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!y_valid && n < 300) begin
            @(posedge clk);
            #1 x_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            n++;
        end
        chk("t4_reach_out", longint'(y_valid), 1);
        hold = acc;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_yv_held", longint'(y_valid), 1);
            chk("t4_ctrl_quiet", longint'({en_acc, clear_acc, addr_x, addr_f}), 0);
            chk("t4_result", acc, hold);
        end
        @(posedge clk);
        #1 y_ready = 1'b1;
        x_valid = 1'b0;

        // Reset in S_MAC at i=10, k=2.
        n = 0;
        @(negedge clk);
        while (!(vec_y == 10 && !y_valid && en_acc && addr_f == 2'd2) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_mac", longint'(n < 400), 1);
        chk("t5_addr_i10k2", longint'(addr_x), 12);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        x_valid = 1'b1;
        #1;
        chk("t5_xready", longint'(x_ready), 1);
        chk("t5_addr0", longint'(addr_x), 0);
        s_y = n_yhs;
        n = 0;
        while ((n_yhs - s_y) < NOUT && n < 1000) begin
            @(posedge clk);
            #1 x_data = 8'($urandom_range(0, 255));
            n++;
        end
        x_valid = 1'b0;
        chk("t5_results", n_yhs - s_y, NOUT);

        // Random x_valid/y_ready over NVEC vectors from a clean reset.
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        s_x = n_xhs;
        s_y = n_yhs;
        n = 0;
        while ((n_yhs - s_y) < NVEC * NOUT && n < 60000) begin
            x_valid = ((n_xhs - s_x) < NVEC * N) ? 1'($urandom_range(0, 1)) : 1'b0;
            y_ready = 1'($urandom_range(0, 1));
            x_data = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            n++;
        end
        x_valid = 1'b0;
        y_ready = 1'b0;
        chk("t6_x_handshakes", n_xhs - s_x, NVEC * N);
        chk("t6_y_handshakes", n_yhs - s_y, NVEC * NOUT);
        chk("t6_queue_drained", yq.size(), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
